// File: rtl/corelet_v2.sv
// corelet_v2: second-generation corelet.
//
// Datapath: activation SRAM -> L0 -> MAC array -> OFIFO -> raw read port
//                                               \-> SFU accumulators -> sfu_out
//           weight SRAM     -> IFIFO -> MAC in_n (output-stationary mode only)
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   activation_in   L0 write data (bw per row lane); also carries weights for load
//   weight_in       IFIFO write data (bw per column lane), used in OS mode
//   inst            [0] load  [1] execute  [2] l0_wr  [3] l0_rd  [4] ififo_wr
//                   [5] ififo_rd  [6] ofifo_rd  [7] acc_en  [8] acc_clear  [9] sfu_rd
//   mode_req        requested mode, 0 = WS, 1 = OS; taken only when idle
//   acc_addr        SFU accumulate address (with ofifo_rd & acc_en)
//   rd_addr         SFU read address (with sfu_rd)
//   relu_en         clamp negative lanes to 0 on SFU read
//   corelet_out     OFIFO head (0 when the OFIFO is empty)
//   o_valid         OFIFO holds data
//   o_ready         L0 and IFIFO can both accept a write
//   o_full          any of L0, IFIFO, OFIFO full
//   sfu_out         registered SFU read data, holds when sfu_valid=0
//   sfu_valid       one-cycle pulse the cycle after sfu_rd
//   mode            active mode register
//   sat_flag        sticky: set by any clamped accumulate, cleared by acc_clear
//
// Handshake: every FIFO accepts a write only when not full and honours a read
// only when not empty; a request against a full/empty FIFO is dropped with no
// state change. o_valid/o_ready are the level indications the caller must
// consult before issuing reads/writes; nothing is back-pressured internally.
//
// MAC array model: each column c holds a row-wide weight vector w[c]. A load
// pops L0 and shifts the popped vector into column 0 (older columns move one
// column east), so col loads fill the array. An execute pops L0 and computes,
// for every column, in_n[c] + sum_r act[r] * w[c][r], where activations are
// unsigned and weights are signed bw-bit values. Results are registered and
// written to the OFIFO one cycle after the execute.

module corelet_v2_fifo #(
   parameter int width = 32,
   parameter int depth = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr,
   input  logic [width-1:0] wdata,
   input  logic             rd,
   output logic [width-1:0] rdata,
   output logic             empty,
   output logic             full
);
   // depth must be a power of two so the pointers wrap naturally
   localparam int aw = $clog2(depth);

   logic [width-1:0] mem [depth];
   logic [aw-1:0]    wr_ptr;
   logic [aw-1:0]    rd_ptr;
   logic [aw:0]      count;
   logic             do_wr;
   logic             do_rd;

   assign empty = (count == '0);
   assign full  = (count == (aw+1)'(depth));
   assign do_wr = wr && !full;
   assign do_rd = rd && !empty;
   // Masked so a drained FIFO presents 0 rather than stale storage.
   assign rdata = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + aw'(1);
         if (do_rd) rd_ptr <= rd_ptr + aw'(1);
         case ({do_wr, do_rd})
            2'b10:   count <= count + (aw+1)'(1);
            2'b01:   count <= count - (aw+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wdata;
   end
endmodule

module corelet_v2 #(
   parameter int bw        = 4,
   parameter int psum_bw   = 16,
   parameter int row       = 8,
   parameter int col       = 8,
   parameter int acc_depth = 16,
   parameter int acc_aw    = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [bw*row-1:0]      activation_in,
   input  logic [bw*col-1:0]      weight_in,
   input  logic [9:0]             inst,
   input  logic                   mode_req,
   input  logic [acc_aw-1:0]      acc_addr,
   input  logic [acc_aw-1:0]      rd_addr,
   input  logic                   relu_en,
   output logic [psum_bw*col-1:0] corelet_out,
   output logic                   o_valid,
   output logic                   o_ready,
   output logic                   o_full,
   output logic [psum_bw*col-1:0] sfu_out,
   output logic                   sfu_valid,
   output logic                   mode,
   output logic                   sat_flag
);
   localparam int fifo_depth = 8;

   // instruction decode
   logic inst_load, inst_exec, l0_wr, l0_rd, ififo_wr, ififo_rd;
   logic ofifo_rd, acc_en, acc_clear, sfu_rd;

   assign inst_load = inst[0];
   assign inst_exec = inst[1];
   assign l0_wr     = inst[2];
   assign l0_rd     = inst[3];
   assign ififo_wr  = inst[4];
   assign ififo_rd  = inst[5];
   assign ofifo_rd  = inst[6];
   assign acc_en    = inst[7];
   assign acc_clear = inst[8];
   assign sfu_rd    = inst[9];

   // FIFOs
   logic [bw*row-1:0]      l0_data;
   logic                   l0_empty, l0_full;
   logic [bw*col-1:0]      ififo_data;
   logic                   ififo_empty, ififo_full;
   logic [psum_bw*col-1:0] ofifo_data;
   logic                   ofifo_empty, ofifo_full;
   logic [psum_bw*col-1:0] mac_out;
   logic [col-1:0]         mac_valid;

   corelet_v2_fifo #(.width(bw*row), .depth(fifo_depth)) u_l0 (
      .clk   (clk),
      .reset (reset),
      .wr    (l0_wr),
      .wdata (activation_in),
      .rd    (l0_rd),
      .rdata (l0_data),
      .empty (l0_empty),
      .full  (l0_full)
   );

   // The IFIFO is only live in OS mode; in WS mode its requests are dropped.
   corelet_v2_fifo #(.width(bw*col), .depth(fifo_depth)) u_ififo (
      .clk   (clk),
      .reset (reset),
      .wr    (ififo_wr && mode),
      .wdata (weight_in),
      .rd    (ififo_rd && mode),
      .rdata (ififo_data),
      .empty (ififo_empty),
      .full  (ififo_full)
   );

   // All columns of one execute complete together, so the column valid
   // vector is either all ones or all zeros.
   corelet_v2_fifo #(.width(psum_bw*col), .depth(fifo_depth)) u_ofifo (
      .clk   (clk),
      .reset (reset),
      .wr    (&mac_valid),
      .wdata (mac_out),
      .rd    (ofifo_rd),
      .rdata (ofifo_data),
      .empty (ofifo_empty),
      .full  (ofifo_full)
   );

   assign corelet_out = ofifo_data;
   assign o_valid     = !ofifo_empty;
   assign o_ready     = !l0_full && !ififo_full;
   assign o_full      = l0_full || ififo_full || ofifo_full;

   // Mode register: only switch when nothing is in flight.
   logic idle;
   assign idle = l0_empty && ififo_empty && ofifo_empty && (inst[1:0] == 2'b00);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)     mode <= 1'b0;
      else if (idle) mode <= mode_req;
   end

   // MAC array
   logic                   l0_pop;
   logic                   load_fire;
   logic                   exec_fire;
   logic [bw*row-1:0]      w_reg [col];
   logic [psum_bw*col-1:0] in_n;
   logic [psum_bw*col-1:0] mac_next;

   assign l0_pop    = l0_rd && !l0_empty;
   assign load_fire = inst_load && l0_pop;
   assign exec_fire = inst_exec && l0_pop;

   // North input: zero in WS, zero-extended IFIFO head in OS.
   always_comb begin
      in_n = '0;
      if (mode) begin
         for (int c = 0; c < col; c++)
            in_n[c*psum_bw +: psum_bw] = psum_bw'(ififo_data[c*bw +: bw]);
      end
   end

   function automatic logic [psum_bw-1:0] mac_col(
      input logic [bw*row-1:0]  act,
      input logic [bw*row-1:0]  wgt,
      input logic [psum_bw-1:0] n
   );
      logic signed [psum_bw-1:0] s;
      logic signed [psum_bw-1:0] a_ext;
      logic signed [psum_bw-1:0] w_ext;
      s = $signed(n);
      for (int r = 0; r < row; r++) begin
         a_ext = $signed(psum_bw'(act[r*bw +: bw]));
         w_ext = psum_bw'($signed(wgt[r*bw +: bw]));
         s     = s + a_ext * w_ext;
      end
      return s;
   endfunction

   always_comb begin
      mac_next = '0;
      for (int c = 0; c < col; c++)
         mac_next[c*psum_bw +: psum_bw] =
            mac_col(l0_data, w_reg[c], in_n[c*psum_bw +: psum_bw]);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int c = 0; c < col; c++) w_reg[c] <= '0;
         mac_valid <= '0;
         mac_out   <= '0;
      end else begin
         if (load_fire) begin
            w_reg[0] <= l0_data;
            for (int c = 1; c < col; c++) w_reg[c] <= w_reg[c-1];
         end
         mac_valid <= {col{exec_fire}};
         if (exec_fire) mac_out <= mac_next;
      end
   end

   // SFU: per-address saturating accumulate with ReLU on read
   logic [psum_bw*col-1:0] acc [acc_depth];
   logic [psum_bw*col-1:0] acc_cur;
   logic [psum_bw*col-1:0] acc_sum;
   logic [col-1:0]         lane_sat;
   logic [psum_bw*col-1:0] rd_val;
   logic                   acc_fire;

   assign acc_fire = ofifo_rd && !ofifo_empty && acc_en;
   assign acc_cur  = acc[acc_addr];

   // Returns {clamped, result}. Overflow is detected by the two top bits of
   // the one-bit-wider sum disagreeing.
   function automatic logic [psum_bw:0] sat_add(
      input logic [psum_bw-1:0] a,
      input logic [psum_bw-1:0] b
   );
      logic signed [psum_bw:0] s;
      s = $signed({a[psum_bw-1], a}) + $signed({b[psum_bw-1], b});
      if (s[psum_bw] != s[psum_bw-1]) begin
         if (s[psum_bw]) return {1'b1, 1'b1, {(psum_bw-1){1'b0}}};
         else            return {1'b1, 1'b0, {(psum_bw-1){1'b1}}};
      end
      return {1'b0, s[psum_bw-1:0]};
   endfunction

   always_comb begin
      acc_sum  = '0;
      lane_sat = '0;
      for (int c = 0; c < col; c++)
         {lane_sat[c], acc_sum[c*psum_bw +: psum_bw]} =
            sat_add(acc_cur[c*psum_bw +: psum_bw], ofifo_data[c*psum_bw +: psum_bw]);
   end

   always_comb begin
      rd_val = acc[rd_addr];
      if (relu_en) begin
         for (int c = 0; c < col; c++)
            if (rd_val[c*psum_bw + psum_bw - 1]) rd_val[c*psum_bw +: psum_bw] = '0;
      end
   end

   // acc_clear outranks a same-cycle accumulate and its saturation event.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < acc_depth; i++) acc[i] <= '0;
         sat_flag <= 1'b0;
      end else if (acc_clear) begin
         for (int i = 0; i < acc_depth; i++) acc[i] <= '0;
         sat_flag <= 1'b0;
      end else if (acc_fire) begin
         acc[acc_addr] <= acc_sum;
         if (|lane_sat) sat_flag <= 1'b1;
      end
   end

   // rd_val is built from the pre-edge array, giving read-before-write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sfu_out   <= '0;
         sfu_valid <= 1'b0;
      end else begin
         sfu_valid <= sfu_rd;
         if (sfu_rd) sfu_out <= rd_val;
      end
   end
endmodule

// File: tb/tb_corelet_v2.sv
// tb_corelet_v2: directed self-checking bench for corelet_v2 with
// hand-computed expected values.
module tb_corelet_v2;
   logic         clk;
   logic         reset;
   logic [31:0]  activation_in;
   logic [31:0]  weight_in;
   logic [9:0]   inst;
   logic         mode_req;
   logic [3:0]   acc_addr;
   logic [3:0]   rd_addr;
   logic         relu_en;
   logic [127:0] corelet_out;
   logic         o_valid;
   logic         o_ready;
   logic         o_full;
   logic [127:0] sfu_out;
   logic         sfu_valid;
   logic         mode;
   logic         sat_flag;

   localparam logic [9:0] i_load = 10'h001;
   localparam logic [9:0] i_exec = 10'h002;
   localparam logic [9:0] i_l0w  = 10'h004;
   localparam logic [9:0] i_l0r  = 10'h008;
   localparam logic [9:0] i_ifw  = 10'h010;
   localparam logic [9:0] i_ifr  = 10'h020;
   localparam logic [9:0] i_ofr  = 10'h040;
   localparam logic [9:0] i_acc  = 10'h080;
   localparam logic [9:0] i_clr  = 10'h100;
   localparam logic [9:0] i_sfu  = 10'h200;

   int n_vec  = 0;
   int n_miss = 0;

   corelet_v2 dut (
      .clk           (clk),
      .reset         (reset),
      .activation_in (activation_in),
      .weight_in     (weight_in),
      .inst          (inst),
      .mode_req      (mode_req),
      .acc_addr      (acc_addr),
      .rd_addr       (rd_addr),
      .relu_en       (relu_en),
      .corelet_out   (corelet_out),
      .o_valid       (o_valid),
      .o_ready       (o_ready),
      .o_full        (o_full),
      .sfu_out       (sfu_out),
      .sfu_valid     (sfu_valid),
      .mode          (mode),
      .sat_flag      (sat_flag)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] rep16(input logic [15:0] v);
      return {8{v}};
   endfunction

   // driver tasks: inputs change 1 time unit after the rising edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic l0_push(input logic [31:0] v);
      activation_in = v;
      inst = i_l0w;
      cyc();
      inst = '0;
   endtask

   task automatic load_weights(input logic [31:0] v);
      for (int i = 0; i < 8; i++) l0_push(v);
      for (int i = 0; i < 8; i++) begin
         inst = i_l0r | i_load;
         cyc();
      end
      inst = '0;
   endtask

   task automatic wait_ovalid();
      int n;
      n = 0;
      while (!o_valid && n < 10) begin
         cyc();
         n++;
      end
      if (!o_valid) check("o_valid_timeout", {127'd0, o_valid}, 128'd1);
   endtask

   // push one activation, execute, then pop the result with extra inst bits
   task automatic run_pass(input logic [31:0] act, input logic [9:0] extra,
                           input logic [3:0] addr, output logic [127:0] head);
      l0_push(act);
      inst = i_l0r | i_exec;
      cyc();
      inst = '0;
      wait_ovalid();
      head = corelet_out;
      acc_addr = addr;
      inst = i_ofr | extra;
      cyc();
      inst = '0;
   endtask

   task automatic sfu_read(input logic [3:0] addr, input logic relu, output logic [127:0] v);
      rd_addr = addr;
      relu_en = relu;
      inst = i_sfu;
      cyc();
      inst = '0;
      relu_en = 1'b0;
      check("sfu_valid_pulse", {127'd0, sfu_valid}, 128'd1);
      v = sfu_out;
   endtask

   logic [127:0] h;
   logic [127:0] v;
   logic [15:0]  e;

   initial begin
      reset = 1'b1;
      activation_in = '0;
      weight_in = '0;
      inst = '0;
      mode_req = 1'b0;
      acc_addr = '0;
      rd_addr = '0;
      relu_en = 1'b0;
      #1;
      check("rst_corelet_out", corelet_out, 128'd0);
      check("rst_o_valid", {127'd0, o_valid}, 128'd0);
      check("rst_o_ready", {127'd0, o_ready}, 128'd1);
      check("rst_o_full", {127'd0, o_full}, 128'd0);
      check("rst_sfu", {sfu_out[126:0], sfu_valid}, 128'd0);
      check("rst_mode_sat", {126'd0, mode, sat_flag}, 128'd0);
      cyc();
      cyc();
      reset = 1'b0;
      cyc();

      // WS basic: weights 1, activations 1 -> 8 per lane
      load_weights(32'h1111_1111);
      run_pass(32'h1111_1111, 10'h000, 4'd0, h);
      check("ws_basic", h, rep16(16'd8));
      check("ws_drained", {127'd0, o_valid}, 128'd0);

      // accumulate twice into address 3
      run_pass(32'h1111_1111, i_acc, 4'd3, h);
      run_pass(32'h1111_1111, i_acc, 4'd3, h);
      sfu_read(4'd3, 1'b0, v);
      check("acc_twice", v, rep16(16'd16));
      cyc();
      check("sfu_valid_drop", {127'd0, sfu_valid}, 128'd0);
      check("sfu_hold", sfu_out, rep16(16'd16));

      // read/accumulate on an empty OFIFO does nothing
      acc_addr = 4'd3;
      inst = i_ofr | i_acc;
      cyc();
      inst = '0;
      check("empty_rd_out", corelet_out, 128'd0);
      sfu_read(4'd3, 1'b0, v);
      check("empty_rd_acc", v, rep16(16'd16));

      // same-cycle accumulate and read of address 2 returns the old value
      run_pass(32'h1111_1111, i_acc, 4'd2, h);
      rd_addr = 4'd2;
      run_pass(32'h1111_1111, i_acc | i_sfu, 4'd2, h);
      check("rbw_valid", {127'd0, sfu_valid}, 128'd1);
      check("rbw_old", sfu_out, rep16(16'd8));
      sfu_read(4'd2, 1'b0, v);
      check("rbw_new", v, rep16(16'd16));

      // acc_clear beats a same-cycle accumulate
      run_pass(32'h1111_1111, i_acc | i_clr, 4'd4, h);
      sfu_read(4'd4, 1'b0, v);
      check("clr_beats_acc", v, 128'd0);
      sfu_read(4'd3, 1'b0, v);
      check("clr_all", v, 128'd0);

      // saturation: 39 passes of 8*15*7=840 reach 32760, then +8 clamps
      load_weights(32'h7777_7777);
      for (int i = 0; i < 39; i++) begin
         run_pass(32'hFFFF_FFFF, i_acc, 4'd0, h);
         if (i == 0) check("psum_840", h, rep16(16'd840));
      end
      sfu_read(4'd0, 1'b0, v);
      check("acc_32760", v, rep16(16'd32760));
      check("no_sat_yet", {127'd0, sat_flag}, 128'd0);
      load_weights(32'h1111_1111);
      run_pass(32'h1111_1111, i_acc, 4'd0, h);
      check("sat_set", {127'd0, sat_flag}, 128'd1);
      sfu_read(4'd0, 1'b0, v);
      check("sat_clamp", v, rep16(16'h7FFF));
      inst = i_clr;
      cyc();
      inst = '0;
      check("sat_cleared", {127'd0, sat_flag}, 128'd0);
      sfu_read(4'd0, 1'b0, v);
      check("clr_zero", v, 128'd0);

      // ReLU: weights -1, activation 5 on row 0 -> -5
      load_weights(32'hFFFF_FFFF);
      run_pass(32'h0000_0005, i_acc, 4'd5, h);
      check("neg_psum", h, rep16(16'hFFFB));
      sfu_read(4'd5, 1'b1, v);
      check("relu_on", v, 128'd0);
      sfu_read(4'd5, 1'b0, v);
      check("relu_off", v, rep16(16'hFFFB));

      // mode gating
      l0_push(32'h1111_1111);
      mode_req = 1'b1;
      cyc();
      check("mode_hold_busy", {127'd0, mode}, 128'd0);
      inst = i_l0r;
      cyc();
      inst = '0;
      check("mode_hold_drain", {127'd0, mode}, 128'd0);
      cyc();
      check("mode_os", {127'd0, mode}, 128'd1);

      // OS: IFIFO head feeds in_n: 3 + 8*(-1) = -5; after pop, -8
      weight_in = 32'h3333_3333;
      inst = i_ifw;
      cyc();
      inst = '0;
      run_pass(32'h1111_1111, 10'h000, 4'd0, h);
      check("os_in_n", h, rep16(16'hFFFB));
      inst = i_ifr;
      cyc();
      inst = '0;
      run_pass(32'h1111_1111, 10'h000, 4'd0, h);
      check("os_popped", h, rep16(16'hFFF8));

      // WS ignores ififo_wr: switching back to OS still succeeds (IFIFO empty)
      mode_req = 1'b0;
      cyc();
      check("mode_ws", {127'd0, mode}, 128'd0);
      weight_in = 32'hFFFF_FFFF;
      inst = i_ifw;
      cyc();
      inst = '0;
      mode_req = 1'b1;
      cyc();
      check("ws_ififo_empty", {127'd0, mode}, 128'd1);
      run_pass(32'h1111_1111, 10'h000, 4'd0, h);
      check("os_no_in_n", h, rep16(16'hFFF8));
      mode_req = 1'b0;
      cyc();
      check("mode_ws_again", {127'd0, mode}, 128'd0);

      // L0 depth: 8 entries fill it, a 9th is dropped
      for (int k = 1; k <= 8; k++) l0_push(32'(k));
      check("l0_full", {126'd0, o_full, o_ready}, 128'd2);
      l0_push(32'd9);
      check("l0_full_hold", {126'd0, o_full, o_ready}, 128'd2);
      for (int k = 0; k < 8; k++) begin
         inst = i_l0r | i_exec;
         cyc();
      end
      inst = '0;
      cyc();
      check("ofifo_full", {126'd0, o_full, o_ready}, 128'd3);
      for (int k = 1; k <= 8; k++) begin
         e = 16'(0 - k);
         check("l0_order", corelet_out, rep16(e));
         inst = i_ofr;
         cyc();
      end
      inst = '0;
      check("ofifo_drained", {127'd0, o_valid}, 128'd0);
      inst = i_l0r | i_exec;
      cyc();
      inst = '0;
      cyc();
      cyc();
      check("l0_extra_ignored", {127'd0, o_valid}, 128'd0);

      // reset mid-run
      run_pass(32'h1111_1111, i_acc, 4'd1, h);
      sfu_read(4'd1, 1'b0, v);
      check("pre_rst_acc", v, rep16(16'hFFF8));
      mode_req = 1'b1;
      cyc();
      for (int k = 0; k < 4; k++) l0_push(32'h1111_1111);
      weight_in = 32'h2222_2222;
      inst = i_ifw;
      cyc();
      cyc();
      inst = i_l0r | i_exec;
      cyc();
      cyc();
      inst = '0;
      cyc();
      check("pre_rst_busy", {125'd0, mode, o_valid, o_full}, 128'd6);
      reset = 1'b1;
      #1;
      check("arst_out", corelet_out, 128'd0);
      check("arst_flags", {124'd0, o_valid, o_ready, o_full, mode}, 128'd4);
      check("arst_sfu", {sfu_out[126:0], sfu_valid}, 128'd0);
      mode_req = 1'b0;
      cyc();
      reset = 1'b0;
      cyc();
      sfu_read(4'd1, 1'b0, v);
      check("post_rst_acc", v, 128'd0);
      check("post_rst_empty", {127'd0, o_valid}, 128'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/corelet_v2.md
Name: corelet_v2

Overview:
Second-generation corelet. It wraps L0, a now-present IFIFO, the MAC array, the OFIFO, and a new special-function unit (SFU) that does per-address psum accumulation with optional ReLU. It adds a run-time weight-stationary/output-stationary mode and sticky status flags. It sits between the core's activation/weight SRAM readers and the psum SRAM writer.

Parameters:
bw, 4, activation/weight bit width
psum_bw, 16, partial-sum width (signed, two's complement)
row, 8, MAC array rows / L0 channels
col, 8, MAC array columns / IFIFO and OFIFO channels
acc_depth, 16, SFU accumulator entries (power of two)
acc_aw, 4, SFU address width, equal to log2(acc_depth)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
activation_in  input  bw*row  L0 write data
weight_in  input  bw*col  IFIFO write data (north weights in OS mode)
inst  input  10  [1:0] mac inst_w (execute, load); [2] l0_wr; [3] l0_rd; [4] ififo_wr; [5] ififo_rd; [6] ofifo_rd; [7] acc_en; [8] acc_clear; [9] sfu_rd
mode_req  input  1  requested mode: 0 = weight-stationary (WS), 1 = output-stationary (OS)
acc_addr  input  acc_aw  SFU accumulate address (used with ofifo_rd & acc_en)
rd_addr  input  acc_aw  SFU read address
relu_en  input  1  apply ReLU on SFU read
corelet_out  output  psum_bw*col  raw OFIFO read data
o_valid  output  1  OFIFO has data
o_ready  output  1  L0 ready AND IFIFO ready
o_full  output  1  L0 full OR IFIFO full OR OFIFO full
sfu_out  output  psum_bw*col  SFU read data
sfu_valid  output  1  sfu_out valid this cycle
mode  output  1  active mode register
sat_flag  output  1  sticky saturation indicator

Behaviour:
- Reset (asynchronous, active-high): all FIFOs empty, mode=0, every accumulator=0, sfu_out=0, sfu_valid=0, sat_flag=0. Corelet_out follows the empty OFIFO (0). o_ready=1, o_full=0, o_valid=0. Reset mid-operation discards all in-flight data.
- Mode register: loads mode_req only in an idle cycle, defined as L0, IFIFO and OFIFO all empty and inst[1:0]==0. Otherwise it holds.
- Data path in WS mode: MAC in_n is driven with all zeros, and ififo_rd/ififo_wr are ignored.
- Data path in OS mode: MAC in_n is the IFIFO output (each bw lane zero-extended to psum_bw), and IFIFO pops on ififo_rd.
- FIFO rules: a write to a full FIFO and a read from an empty FIFO are ignored, with no state change. Simultaneous read and write on a non-full, non-empty FIFO both take effect. OFIFO write enable is the per-column MAC valid vector.
- Raw read: corelet_out is the OFIFO head. It pops on ofifo_rd when o_valid=1.
- Accumulate:
  - Trigger: ofifo_rd=1, o_valid=1, acc_en=1.
  - Action: acc[acc_addr] lane i += popped lane i. Signed saturating add, clamped to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
  - Result is visible from the next cycle.
  - Any clamp sets sat_flag.
  - acc_en=1 with an empty OFIFO: no effect.
- acc_clear: synchronously zeroes all accumulators and sat_flag.
  - Priority: acc_clear beats a same-cycle accumulate, so the entry ends at 0.
  - Priority: acc_clear beats a same-cycle saturation event, so sat_flag ends at 0.
- SFU read (sfu_rd): 1-cycle latency. sfu_valid=1 in the following cycle.
  - Value: acc[rd_addr] sampled before any same-cycle accumulate (read-before-write).
  - ReLU: if relu_en (sampled with sfu_rd), negative lanes read as 0.
  - Hold: sfu_out holds its last value when sfu_valid=0.
- Address wrap: addresses are acc_aw bits, so no out-of-range access exists.

Test Plan:
- WS basic, row=col=8: load all weights=1, push 1 activation vector of all 1s, execute, ofifo_rd with acc_en=0 -> every corelet_out lane = 8; o_valid drops after the pop.
- Accumulate twice: two passes as above into acc_addr=3, then sfu_rd rd_addr=3 -> sfu_out lanes = 16 one cycle later, sfu_valid pulses for 1 cycle.
- Saturation and ReLU:
  - Preload acc[0] lanes=32760, accumulate psum 8 -> lanes=32767 and sat_flag=1.
  - Then acc_clear -> sfu_rd addr 0 returns 0 and sat_flag=0.
  - Separately, acc entry with lane -5 read with relu_en=1 -> 0; with relu_en=0 -> -5.
- Mode gating:
  - mode_req=1 while L0 holds 1 entry -> mode stays 0.
  - After L0 drains and inst[1:0]=0 -> mode=1 next cycle.
  - In OS mode, IFIFO write/read pop works; in WS mode, ififo_wr with weight_in=0xF.. leaves the IFIFO empty.
- Boundaries:
  - Write L0 until full -> o_full=1, o_ready=0; an extra write is ignored, and the entry count is confirmed by reads.
  - ofifo_rd on empty -> corelet_out unchanged, accumulators unchanged.
  - Same-cycle accumulate to addr 2 and sfu_rd addr 2 -> old value returned.
- Reset mid-run: assert reset with all FIFOs half full and acc nonzero -> all outputs at reset values immediately (asynchronous), and sfu_rd after release returns 0.
